div: RTL

DIV -- requirements
Module: div

---
 rtl/div.sv | 137 +++++++++++++
 1 files changed

// File: rtl/div.sv
// Multi-cycle restoring divider (signed/unsigned) with annul and async reset.
// Define DIV_ZERO_SHORTCUT_EN to finish a zero-divisor request via BYZERO with result 0.
module div #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BYZERO = 2'd1;
    localparam logic [1:0] S_ON     = 2'd2;
    localparam logic [1:0] S_END    = 2'd3;

    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             signed_q;
    logic             neg_dvd;
    logic             neg_dvs;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;

    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             take;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] quo_fix;

    // quo_q starts as the dividend magnitude and shifts out one bit per step
    // while quotient bits shift in from the right.
    always_comb begin
        // NOTE: every signal here is assigned on every path, so no latch is inferred.
        mag1    = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        mag2    = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
        shifted = {rem_q, quo_q[WIDTH-1]};
        take    = (shifted >= {1'b0, dvs_q});
        diff    = shifted - {1'b0, dvs_q};
        rem_nxt = take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_nxt = (quo_q << 1) | WIDTH'(take);
        quo_fix = (signed_q && (neg_dvd ^ neg_dvs)) ? -quo_nxt : quo_nxt;
        rem_fix = (signed_q && neg_dvd) ? -rem_nxt : rem_nxt;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            signed_q <= 1'b0;
            neg_dvd  <= 1'b0;
            neg_dvs  <= 1'b0;
            dvs_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (start_i && !annul_i) begin
                        signed_q <= signed_div_i;
                        neg_dvd  <= signed_div_i & opdata1_i[WIDTH-1];
                        neg_dvs  <= signed_div_i & opdata2_i[WIDTH-1];
                        quo_q    <= mag1;
                        dvs_q    <= mag2;
                        rem_q    <= '0;
                        cnt      <= '0;
`ifdef DIV_ZERO_SHORTCUT_EN
                        state    <= (opdata2_i == '0) ? S_BYZERO : S_ON;
`else
                        state    <= S_ON;
`endif
                    end
                end

                S_BYZERO: begin
                    result_o <= '0;
                    ready_o  <= 1'b0;
                    state    <= annul_i ? S_IDLE : S_END;
                end

                S_ON: begin
                    if (annul_i) begin
                        state    <= S_IDLE;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end else begin
                        rem_q <= rem_nxt;
                        quo_q <= quo_nxt;
                        cnt   <= cnt + CW'(1);
                        // Final step: sign-correct while registering the result.
                        if (cnt == LAST_STEP) begin
                            state    <= S_END;
                            result_o <= {rem_fix, quo_fix};
                            ready_o  <= 1'b1;
                        end
                    end
                end

                S_END: begin
                    if (start_i) begin
                        ready_o <= 1'b1;
                    end else begin
                        state    <= S_IDLE;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    ready_o  <= 1'b0;
                    result_o <= '0;
                end
            endcase
        end
    end

endmodule
